// File: rtl/spi_master_ctrl_if.sv
// Host-side command/response bus of the SPI master controller.
//   cmd_valid/cmd_ready/cmd_op/cmd_data : command handshake (op + byte)
//   rsp_valid/rsp_data                  : read byte returned by RD_DATA
//   busy                                : frame in progress
// modport master = host side, modport slave = controller side.
interface spi_master_ctrl_if #(
    parameter int unsigned DATA_W = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [DATA_W-1:0] cmd_data;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              busy;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_data,
        input  cmd_ready,
        input  rsp_valid,
        input  rsp_data,
        input  busy
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_data,
        output cmd_ready,
        output rsp_valid,
        output rsp_data,
        output busy
    );
endinterface

// File: rtl/spi_master_ctrl.sv
// Single-lane SPI master for the SPI slave + RAM wrapper.
// Turns a host command {op, byte} into a slave frame: SS_n low, a select bit
// (op[1]), DATA_W+2 payload bits LSB first (op bits last), and for RD_DATA a
// turnaround cycle followed by a DATA_W-bit MISO capture.
// Ports:
//   clk, rst   : system clock, synchronous active-high reset
//   bus        : host command/response interface (slave modport)
//   SS_n       : slave select, active-low (registered)
//   MOSI       : serial data to slave (registered)
//   MISO       : serial data from slave, only sampled while receiving
module spi_master_ctrl #(
    parameter int unsigned GAP_CYCLES = 1,
    parameter int unsigned DATA_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    spi_master_ctrl_if.slave bus,
    output logic             SS_n,
    output logic             MOSI,
    input  logic             MISO
);

    localparam int unsigned PayW = DATA_W + 2;
    localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [1:0] OpRdData = 2'b11;

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StStart = 3'd1;
    localparam logic [2:0] StSel   = 3'd2;
    localparam logic [2:0] StShift = 3'd3;
    localparam logic [2:0] StTurn  = 3'd4;
    localparam logic [2:0] StRecv  = 3'd5;

    logic [2:0]        state_q,     state_d;
    logic [1:0]        op_q,        op_d;
    logic [PayW-1:0]   payload_q,   payload_d;
    logic [3:0]        bit_cnt_q,   bit_cnt_d;
    logic [GapW-1:0]   gap_cnt_q,   gap_cnt_d;
    logic [DATA_W-1:0] rd_shift_q,  rd_shift_d;
    logic              ss_n_q,      ss_n_d;
    logic              mosi_q,      mosi_d;
    logic              busy_q,      busy_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q,  rsp_data_d;

    logic accept;

    // Only combinational output: the gap counter holds off the next frame.
    assign bus.cmd_ready = (state_q == StIdle) && (gap_cnt_q == '0) && !rst;
    assign accept        = bus.cmd_valid && bus.cmd_ready;

    assign SS_n          = ss_n_q;
    assign MOSI          = mosi_q;
    assign bus.busy      = busy_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        payload_d   = payload_q;
        bit_cnt_d   = bit_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        rd_shift_d  = rd_shift_q;
        ss_n_d      = ss_n_q;
        mosi_d      = mosi_q;
        busy_d      = busy_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;

        case (state_q)
            StIdle: begin
                if (gap_cnt_q != '0) begin
                    gap_cnt_d = gap_cnt_q - GapW'(1);
                end
                if (accept) begin
                    op_d      = bus.cmd_op;
                    // RD_DATA carries no data byte on the wire.
                    payload_d = {bus.cmd_op,
                                 (bus.cmd_op == OpRdData) ? {DATA_W{1'b0}} : bus.cmd_data};
                    state_d   = StStart;
                    ss_n_d    = 1'b0;
                    mosi_d    = 1'b0;
                    busy_d    = 1'b1;
                end
            end
            StStart: begin
                state_d = StSel;
                mosi_d  = op_q[1];
            end
            StSel: begin
                state_d   = StShift;
                mosi_d    = payload_q[0];
                bit_cnt_d = 4'd1;
            end
            StShift: begin
                if (bit_cnt_q != 4'(PayW)) begin
                    mosi_d    = |(payload_q & (PayW'(1) << bit_cnt_q));
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end else if (op_q == OpRdData) begin
                    state_d = StTurn;
                    mosi_d  = 1'b0;
                end else begin
                    state_d   = StIdle;
                    ss_n_d    = 1'b1;
                    mosi_d    = 1'b0;
                    busy_d    = 1'b0;
                    gap_cnt_d = GapW'(GAP_CYCLES - 1);
                end
            end
            StTurn: begin
                state_d    = StRecv;
                bit_cnt_d  = 4'd0;
                rd_shift_d = '0;
            end
            StRecv: begin
                // DATA_W sampling edges, then one more edge to close the frame.
                if (bit_cnt_q != 4'(DATA_W)) begin
                    rd_shift_d = rd_shift_q | (DATA_W'(MISO) << bit_cnt_q);
                    bit_cnt_d  = bit_cnt_q + 4'd1;
                end else begin
                    state_d     = StIdle;
                    ss_n_d      = 1'b1;
                    mosi_d      = 1'b0;
                    busy_d      = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = rd_shift_q;
                    gap_cnt_d   = GapW'(GAP_CYCLES - 1);
                end
            end
            default: begin
                state_d = StIdle;
                ss_n_d  = 1'b1;
                mosi_d  = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            op_q        <= 2'b00;
            payload_q   <= '0;
            bit_cnt_q   <= 4'd0;
            gap_cnt_q   <= '0;
            rd_shift_q  <= '0;
            ss_n_q      <= 1'b1;
            mosi_q      <= 1'b0;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            payload_q   <= payload_d;
            bit_cnt_q   <= bit_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            rd_shift_q  <= rd_shift_d;
            ss_n_q      <= ss_n_d;
            mosi_q      <= mosi_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: a GAP_CYCLES=1 instance with a behavioural SPI RAM
// slave and scoreboards for frames, SS_n low lengths and read responses, plus a
// GAP_CYCLES=3 instance for the inter-frame gap.
module tb_spi_master_ctrl;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic ss_n, mosi;
    logic miso = 1'b0;
    logic ss3, mosi3;

    spi_master_ctrl_if #(.DATA_W(DW)) bus ();
    spi_master_ctrl_if #(.DATA_W(DW)) bus3 ();

    spi_master_ctrl #(.GAP_CYCLES(1), .DATA_W(DW)) u_dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .SS_n (ss_n),
        .MOSI (mosi),
        .MISO (miso)
    );

    spi_master_ctrl #(.GAP_CYCLES(3), .DATA_W(DW)) u_dut3 (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus3),
        .SS_n (ss3),
        .MOSI (mosi3),
        .MISO (1'b0)
    );

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    logic [11:0] exp_frame[$];
    int          exp_len[$];
    logic [7:0]  exp_rsp[$];

    logic [7:0] mem[256];
    logic [7:0] waddr = 8'h00;
    logic [7:0] raddr = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // MOSI seen after E0..E11: START 0, select bit op[1], then payload LSB first.
    function automatic logic [11:0] frame_of(input logic [1:0] op, input logic [7:0] d);
        logic [7:0] dd;
        dd = (op == 2'b11) ? 8'h00 : d;
        return {op, dd, op[1], 1'b0};
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Behavioural slave + monitors, all sampled on the falling edge.
    initial begin
        int n;
        int lo;
        logic [11:0] fr;
        logic [7:0]  rb;
        n  = 0;
        lo = 0;
        fr = '0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        forever begin
            @(negedge clk);
            if (!ss_n) begin
                n++;
                lo++;
                if (n <= 12) fr[n-1] = mosi;
                if (n == 12) begin
                    if (exp_frame.size() == 0) check("frame_unexpected", 1, 0);
                    else check("frame_bits", {20'h0, fr}, {20'h0, exp_frame.pop_front()});
                    case (fr[11:10])
                        2'b00:   waddr = fr[9:2];
                        2'b01:   mem[waddr] = fr[9:2];
                        2'b10:   raddr = fr[9:2];
                        default: ;
                    endcase
                end
                // Bit i is sampled by the master at edge E(14+i).
                if (n >= 14 && n <= 21) begin
                    rb   = mem[raddr] >> (n - 14);
                    miso = rb[0];
                end else begin
                    miso = 1'b0;
                end
            end else begin
                if (lo > 0) begin
                    if (exp_len.size() == 0) check("ssn_low_unexpected", 1, 0);
                    else check("ssn_low_len", lo, exp_len.pop_front());
                    lo = 0;
                end
                n    = 0;
                miso = 1'b0;
            end
            check("busy_tracks_ssn", bus.busy, !ss_n);
            if (bus.rsp_valid) begin
                if (exp_rsp.size() == 0) begin
                    check("rsp_unexpected", 1, 0);
                end else begin
                    check("rsp_data", bus.rsp_data, exp_rsp.pop_front());
                    check("rsp_with_ssn_high", ss_n, 1);
                end
            end
        end
    end

    // Issue one command; returns the cycle stamp of the negedge before acceptance.
    // cmd_valid is left high so back-to-back commands can be chained.
    task automatic send(input logic [1:0] op, input logic [7:0] d, input int len,
                        output int acc);
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_data  = d;
        exp_frame.push_back(frame_of(op, d));
        exp_len.push_back(len);
        acc = -1;
        for (int i = 0; i < 200; i++) begin
            if (bus.cmd_ready) begin
                acc = cyc;
                @(posedge clk);
                return;
            end
            @(negedge clk);
        end
        check("accept_timeout", 0, 1);
    endtask

    task automatic release_cmd();
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    initial begin
        int a;
        int a1;
        int a2;
        int ok;
        logic [7:0] wa[4];
        logic [7:0] wd[4];
        wa[0] = 8'hFF; wd[0] = 8'hA5;
        wa[1] = 8'h10; wd[1] = 8'h3C;
        wa[2] = 8'h00; wd[2] = 8'h81;
        wa[3] = 8'h7E; wd[3] = 8'hC3;

        bus.cmd_valid  = 1'b0;
        bus.cmd_op     = 2'b00;
        bus.cmd_data   = 8'h00;
        bus3.cmd_valid = 1'b0;
        bus3.cmd_op    = 2'b00;
        bus3.cmd_data  = 8'h00;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ssn", ss_n, 1);
        check("rst_mosi", mosi, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_data", bus.rsp_data, 0);
        check("rst_cmd_ready", bus.cmd_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_cmd_ready", bus.cmd_ready, 1);

        // WR_ADDR 0x5A: MOSI 0,0,0,1,0,1,1,0,1,0,0,0 after E0..E11
        send(2'b00, 8'h5A, 12, a);
        release_cmd();

        // Loopback through the slave model; first read returns 0xA5.
        for (int i = 0; i < 4; i++) begin
            send(2'b00, wa[i], 12, a);
            send(2'b01, wd[i], 12, a);
            release_cmd();
        end
        for (int i = 0; i < 4; i++) begin
            send(2'b10, wa[i], 12, a);
            send(2'b11, 8'hEE, 22, a);
            exp_rsp.push_back(wd[i]);
            release_cmd();
        end

        // Back-to-back with cmd_valid held: 12 low + 1 high cycles between accepts
        send(2'b00, 8'h22, 12, a1);
        send(2'b01, 8'h99, 12, a2);
        release_cmd();
        check("b2b_accept_spacing", a2 - a1, 13);

        // Reset mid-RECV: accepted at E0, rst raised before E16, held two edges
        send(2'b11, 8'h00, 16, a);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        repeat (15) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_ssn", ss_n, 1);
        check("midrst_mosi", mosi, 0);
        check("midrst_busy", bus.busy, 0);
        check("midrst_rsp_data", bus.rsp_data, 0);
        check("midrst_cmd_ready", bus.cmd_ready, 0);
        @(negedge clk);
        check("midrst_cmd_ready2", bus.cmd_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        check("postrst_cmd_ready", bus.cmd_ready, 1);

        // GAP_CYCLES=3: gap counter loads 2 as SS_n rises (after E12), so
        // cmd_ready is 0 for the two cycles after the rise and the held
        // command is taken on the third edge: SS_n high for exactly 3 cycles.
        @(negedge clk);
        bus3.cmd_valid = 1'b1;
        bus3.cmd_op    = 2'b00;
        bus3.cmd_data  = 8'h33;
        ok = 0;
        for (int i = 0; i < 50 && ok == 0; i++) begin
            @(negedge clk);
            if (!ss3) ok = 1;
        end
        check("gap3_first_start", ok, 1);
        ok = 0;
        for (int i = 0; i < 50 && ok == 0; i++) begin
            @(negedge clk);
            if (ss3) ok = 1;
        end
        check("gap3_first_end", ok, 1);
        check("gap3_ready_c1", bus3.cmd_ready, 0);
        @(negedge clk);
        check("gap3_ready_c2", bus3.cmd_ready, 0);
        check("gap3_ssn_c2", ss3, 1);
        @(negedge clk);
        check("gap3_ready_c3", bus3.cmd_ready, 1);
        check("gap3_ssn_c3", ss3, 1);
        @(negedge clk);
        check("gap3_second_start", ss3, 0);
        bus3.cmd_valid = 1'b0;

        repeat (30) @(negedge clk);
        check("frames_left", exp_frame.size(), 0);
        check("lens_left", exp_len.size(), 0);
        check("rsps_left", exp_rsp.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
